// File: rtl/pipe_reg_n.sv
// ============================================================================
// Module   : pipe_reg_n
// Purpose  : STAGES-deep WIDTH-bit pipeline register with valid bits, stall,
//            flush and occupancy count. Option macro: PIPE_REG_N_FLUSH_CLR_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_n #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] O,
  output logic             OUT_VALID,
  output logic [CW-1:0]    COUNT
);

  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [CW-1:0]     r_count;

  logic              w_shift;
  logic              w_data_en;
  logic              w_data_clr;
  logic [CW-1:0]     w_count_next;

  assign w_shift = CE && !FLUSH;

`ifdef PIPE_REG_N_FLUSH_CLR_EN
  assign w_data_clr = !CLR_N || FLUSH;
  assign w_data_en  = w_shift;
`else
  // Flush leaves the datapath on its normal CE schedule; only valid bits drop.
  assign w_data_clr = !CLR_N;
  assign w_data_en  = CE;
`endif

  // Entering and leaving entries balance, so this never exceeds STAGES.
  assign w_count_next = r_count + CW'(IN_VALID) - CW'(r_valid[STAGES-1]);

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [WIDTH-1:0] w_data_in;

      if (i == 0) begin : g_head
        assign w_data_in = D;
      end else begin : g_body
        assign w_data_in = r_data[i-1];
      end

      always_ff @(posedge C) begin
        if (w_data_clr) begin
          r_data[i] <= '0;
        end else if (w_data_en) begin
          r_data[i] <= w_data_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge C) begin
    if (!CLR_N) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (FLUSH) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (w_shift) begin
      if (STAGES == 1) begin
        r_valid <= STAGES'(IN_VALID);
      end else begin
        r_valid <= {r_valid[STAGES-2:0], IN_VALID};
      end
      r_count <= w_count_next;
    end
  end

  assign O         = r_data[STAGES-1];
  assign OUT_VALID = r_valid[STAGES-1];
  assign COUNT     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_n.sv
// ============================================================================
// Module   : tb_pipe_reg_n
// Purpose  : Self-checking bench for pipe_reg_n (WIDTH=16, STAGES=3); honours
//            PIPE_REG_N_FLUSH_CLR_EN. Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_n;

  localparam int WIDTH  = 16;
  localparam int STAGES = 3;
  localparam int CW     = 2;
  localparam int NVEC   = 21;
  localparam int NRAND  = 400;

`ifdef PIPE_REG_N_FLUSH_CLR_EN
  localparam logic [15:0] C_FL5555 = 16'h0000;
  localparam logic [15:0] C_FLBEEF = 16'h0000;
`else
  localparam logic [15:0] C_FL5555 = 16'h5555;
  localparam logic [15:0] C_FLBEEF = 16'hBEEF;
`endif

  logic             clk;
  logic             clr_n;
  logic             ce;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic [WIDTH-1:0] o;
  logic             out_valid;
  logic [CW-1:0]    count;

  int total;
  int bad;

  pipe_reg_n #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .C        (clk),
    .CLR_N    (clr_n),
    .CE       (ce),
    .FLUSH    (flush),
    .D        (d),
    .IN_VALID (in_valid),
    .O        (o),
    .OUT_VALID(out_valid),
    .COUNT    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr_n;
    logic        flush;
    logic        ce;
    logic        iv;
    logic [15:0] d;
    logic [15:0] eo;
    logic        ev;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl [NVEC];

  // Reference model: an ordered list of slots, index 0 nearest the input.
  logic [15:0] m_data  [STAGES];
  logic        m_valid [STAGES];

  task automatic model_edge(input logic c_n, input logic fl, input logic en,
                            input logic iv, input logic [15:0] din);
    if (!c_n) begin
      for (int i = 0; i < STAGES; i++) begin
        m_data[i]  = '0;
        m_valid[i] = 1'b0;
      end
    end else if (fl) begin
`ifdef PIPE_REG_N_FLUSH_CLR_EN
      for (int i = 0; i < STAGES; i++) m_data[i] = '0;
`else
      if (en) begin
        for (int i = STAGES - 1; i > 0; i--) m_data[i] = m_data[i-1];
        m_data[0] = din;
      end
`endif
      for (int i = 0; i < STAGES; i++) m_valid[i] = 1'b0;
    end else if (en) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        m_data[i]  = m_data[i-1];
        m_valid[i] = m_valid[i-1];
      end
      m_data[0]  = din;
      m_valid[0] = iv;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < STAGES; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive, take one rising edge, advance the model, then sample 1 time unit later.
  task automatic step(input logic c_n, input logic fl, input logic en,
                      input logic iv, input logic [15:0] din);
    clr_n    = c_n;
    flush    = fl;
    ce       = en;
    in_valid = iv;
    d        = din;
    @(posedge clk);
    model_edge(c_n, fl, en, iv, din);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    clr_n    = 1'b0;
    flush    = 1'b0;
    ce       = 1'b0;
    in_valid = 1'b0;
    d        = '0;

    //            clr  fl   ce   iv   d         O         ov   cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 2'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD, 16'h0000, 1'b0, 2'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 16'h1234, 1'b1, 2'd3};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hABCD, 1'b1, 2'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hABCD, 1'b1, 2'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, C_FL5555, 1'b0, 2'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 2'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0001, 1'b1, 2'd2};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 2'd1};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003, 1'b1, 2'd1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h0000, 1'b0, 2'd0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h0000, 1'b0, 2'd1};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd1};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hAAAA, 1'b1, 2'd1};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 2'd0};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, C_FLBEEF, 1'b0, 2'd0};

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].clr_n, tbl[i].flush, tbl[i].ce, tbl[i].iv, tbl[i].d);
      check($sformatf("vec%0d_o", i), int'(o), int'(tbl[i].eo));
      check($sformatf("vec%0d_ov", i), int'(out_valid), int'(tbl[i].ev));
      check($sformatf("vec%0d_cnt", i), int'(count), int'(tbl[i].ec));
    end

    // Reset held for several edges with a full pipe of traffic offered.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 16'h7777);
    check("full_cnt", int'(count), 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
      check("rst_hold_o", int'(o), 0);
      check("rst_hold_cnt", int'(count), 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < NRAND; n++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           16'($urandom));
      check("rnd_o", int'(o), int'(m_data[STAGES-1]));
      check("rnd_ov", int'(out_valid), int'(m_valid[STAGES-1]));
      check("rnd_cnt", int'(count), model_count());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
